ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/ldm_stm_sequencer_if.sv | 28 ++
 rtl/ldm_stm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Memory-side bus of the LDM/STM sequencer.
// One outstanding beat: mem_req held with stable payload until mem_ack.
interface ldm_stm_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list in
// ascending order, one memory beat per ack, optional base writeback.
module ldm_stm_sequencer (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        is_load,
    input  logic                        up,
    input  logic                        pre,
    input  logic                        wback,
    input  logic [3:0]                  rn,
    input  logic [31:0]                 base,
    input  logic [15:0]                 reglist,
    output logic [3:0]                  rf_ra,
    input  logic [31:0]                 rf_rd,
    output logic [3:0]                  rf_wa,
    output logic [31:0]                 rf_wd,
    output logic [1:0]                  rf_we,
    ldm_stm_sequencer_if.master         mem,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        LWB,
        WB,
        FIN
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        load_q;
    logic [3:0]  rn_q;
    logic        wb_en_q;
    logic [31:0] wb_val_q;
    logic [15:0] mask_q;
    logic [31:0] addr_q;
    logic        ld_pend;
    logic [3:0]  ld_reg;
    logic [31:0] ld_data;

    logic [4:0]  n_in;
    logic [31:0] off_in;
    logic [31:0] addr_in;
    logic [31:0] wbv_in;
    logic        wb_en_in;
    logic [3:0]  cur;
    logic        last;
    logic        beat;

    // Command decode: register count, start address and writeback value
    always_comb begin
        n_in = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n_in = n_in + {4'd0, reglist[i]};
        end
        off_in = {25'd0, n_in, 2'b00};
        case ({up, pre})
            2'b10:   addr_in = base;
            2'b11:   addr_in = base + 32'd4;
            2'b00:   addr_in = base - off_in + 32'd4;
            default: addr_in = base - off_in;
        endcase
        wbv_in = up ? base + off_in : base - off_in;
        // A loaded base register takes priority over the writeback
        wb_en_in = wback && !(is_load && reglist[rn]);
    end

    // Lowest pending register and end-of-list detection
    always_comb begin
        cur = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) cur = 4'(i);
        end
        last = (mask_q & (mask_q - 16'd1)) == 16'd0;
        beat = (state == XFER) && mem.mem_ack;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = (n_in == 5'd0) ? FIN : XFER;
            end
            XFER: begin
                if (beat && last) begin
                    if (load_q)       state_nx = LWB;
                    else if (wb_en_q) state_nx = WB;
                    else              state_nx = FIN;
                end
            end
            LWB:     state_nx = wb_en_q ? WB : FIN;
            WB:      state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus and register-file outputs decoded from state
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        mem.mem_we    = 1'b0;
        rf_ra         = 4'd0;
        rf_we         = 2'b00;
        rf_wa         = 4'd0;
        rf_wd         = 32'd0;
        busy          = (state != IDLE);
        if (state == XFER) begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = addr_q;
            mem.mem_we   = !load_q;
            if (!load_q) begin
                rf_ra         = cur;
                mem.mem_wdata = rf_rd;
            end
        end
        if (ld_pend) begin
            rf_we = 2'b11;
            rf_wa = ld_reg;
            rf_wd = ld_data;
        end else if (state == WB) begin
            rf_we = 2'b11;
            rf_wa = rn_q;
            rf_wd = wb_val_q;
        end
    end

    // Command latch, beat bookkeeping and load-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q   <= 1'b0;
            rn_q     <= 4'd0;
            wb_en_q  <= 1'b0;
            wb_val_q <= 32'd0;
            mask_q   <= 16'd0;
            addr_q   <= 32'd0;
            ld_pend  <= 1'b0;
            ld_reg   <= 4'd0;
            ld_data  <= 32'd0;
            done     <= 1'b0;
        end else begin
            ld_pend <= beat && load_q;
            done    <= (state == FIN);
            if (state == IDLE && start) begin
                load_q   <= is_load;
                rn_q     <= rn;
                wb_en_q  <= wb_en_in;
                wb_val_q <= wbv_in;
                mask_q   <= reglist;
                addr_q   <= addr_in;
            end
            if (beat) begin
                mask_q <= mask_q & (mask_q - 16'd1);
                addr_q <= addr_q + 32'd4;
                if (load_q) begin
                    ld_reg  <= cur;
                    ld_data <= mem.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a list-level model queues
// expected beats and register writes; a negedge monitor checks them.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        up;
    logic        pre;
    logic        wback;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [1:0]  rf_we;
    logic        busy;
    logic        done;

    ldm_stm_sequencer_if ifc ();

    ldm_stm_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .is_load (is_load),
        .up      (up),
        .pre     (pre),
        .wback   (wback),
        .rn      (rn),
        .base    (base),
        .reglist (reglist),
        .rf_ra   (rf_ra),
        .rf_rd   (rf_rd),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .rf_we   (rf_we),
        .mem     (ifc.master),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_rf [16];
    logic        rd_fix = 1'b0;
    logic [31:0] rd_val = 32'd0;
    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    assign rf_rd = tb_rf[rf_ra];
    assign ifc.mem_rdata = rd_fix ? rd_val : mdata(ifc.mem_addr);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mev_t;

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] wd;
    } rev_t;

    mev_t mq[$];
    rev_t rq[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: expand the command into its beat and write lists
    task automatic expect_op(input logic ld, input logic u, input logic p,
                             input logic w, input logic [3:0] r,
                             input logic [31:0] b, input logic [15:0] rl);
        int n;
        logic [31:0] a;
        logic [31:0] off;
        mev_t me;
        rev_t re;
        n = $countones(rl);
        off = 32'(4 * n);
        if (u) a = p ? b + 32'd4 : b;
        else   a = p ? b - off : b - off + 32'd4;
        if (n == 0) return;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                me.addr  = a;
                me.we    = !ld;
                me.wdata = ld ? 32'd0 : tb_rf[i];
                mq.push_back(me);
                if (ld) begin
                    re.wa = 4'(i);
                    re.wd = rd_fix ? rd_val : mdata(a);
                    rq.push_back(re);
                end
                a = a + 32'd4;
            end
        end
        if (w && !(ld && rl[r])) begin
            re.wa = r;
            re.wd = u ? b + off : b - off;
            rq.push_back(re);
        end
    endtask

    int ack_mode = 0;
    int stall = 0;

    // Memory responder: ack always, randomly, or after a fixed stall
    always @(posedge clk) begin
        if (ifc.mem_req && stall > 0) stall = stall - 1;
        #1;
        case (ack_mode)
            0:       ifc.mem_ack = 1'b1;
            1:       ifc.mem_ack = 1'($urandom_range(0, 1));
            default: ifc.mem_ack = (stall == 0);
        endcase
    end

    logic        stall_v = 1'b0;
    logic [31:0] st_addr;
    logic [31:0] st_wd;
    mev_t        me_m;
    rev_t        re_m;

    // Monitor: stability during stalls, beats, register writes, done
    always @(negedge clk) begin
        if (reset) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v && ifc.mem_req) begin
                chk("hold_addr", ifc.mem_addr, st_addr);
                chk("hold_wdata", ifc.mem_wdata, st_wd);
            end
            if (ifc.mem_req && ifc.mem_ack) begin
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got addr %h want none",
                             ifc.mem_addr);
                end else begin
                    me_m = mq.pop_front();
                    chk("beat_addr", ifc.mem_addr, me_m.addr);
                    chk("beat_we", {31'd0, ifc.mem_we}, {31'd0, me_m.we});
                    if (me_m.we) chk("beat_wdata", ifc.mem_wdata, me_m.wdata);
                end
            end
            stall_v = ifc.mem_req && !ifc.mem_ack;
            st_addr = ifc.mem_addr;
            st_wd   = ifc.mem_wdata;
            if (rf_we != 2'b00) begin
                chk("rf_we_code", {30'd0, rf_we}, 32'd3);
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_rf_write: got R%0d=%h want none",
                             rf_wa, rf_wd);
                end else begin
                    re_m = rq.pop_front();
                    chk("rf_wa", {28'd0, rf_wa}, {28'd0, re_m.wa});
                    chk("rf_wd", rf_wd, re_m.wd);
                end
            end
            if (done) begin
                chk("done_beats_left", 32'(mq.size()), 32'd0);
                chk("done_writes_left", 32'(rq.size()), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic outputs_zero(input string tag);
        chk({tag, "_mem_req"}, {31'd0, ifc.mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, ifc.mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, ifc.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, ifc.mem_wdata, 32'd0);
        chk({tag, "_rf_we"}, {30'd0, rf_we}, 32'd0);
        chk({tag, "_rf_wa"}, {28'd0, rf_wa}, 32'd0);
        chk({tag, "_rf_wd"}, rf_wd, 32'd0);
        chk({tag, "_rf_ra"}, {28'd0, rf_ra}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic scramble_cmd();
        is_load = 1'($urandom);
        up      = 1'($urandom);
        pre     = 1'($urandom);
        wback   = 1'($urandom);
        rn      = 4'($urandom);
        base    = $urandom;
        reglist = 16'($urandom);
    endtask

    task automatic fill_rf();
        for (int i = 0; i < 16; i++) tb_rf[i] = $urandom;
    endtask

    // Issue one command; extra!=0 holds start high into the busy period
    task automatic run_op(input logic ld, input logic u, input logic p,
                          input logic w, input logic [3:0] r,
                          input logic [31:0] b, input logic [15:0] rl,
                          input int am, input int extra);
        int n;
        int lat;
        int cyc;
        logic dwb;
        n = $countones(rl);
        dwb = w && !(ld && rl[r]);
        lat = (n == 0) ? 2 : n + (ld ? 1 : 0) + (dwb ? 1 : 0) + 2;
        ack_mode = am;
        if (am == 2) stall = 3;
        expect_op(ld, u, p, w, r, b, rl);
        @(posedge clk);
        #2;
        is_load = ld;
        up      = u;
        pre     = p;
        wback   = w;
        rn      = r;
        base    = b;
        reglist = rl;
        start   = 1'b1;
        @(posedge clk);
        #2;
        cyc = 1;
        scramble_cmd();
        if (extra == 0) start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (am == 0) chk("first_req", {31'd0, ifc.mem_req}, 32'(n > 0));
        if (extra != 0) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            cyc = 2;
        end
        while (!done && cyc < 400) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (cyc >= 400) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done want done");
        end else if (am == 0) begin
            chk("done_latency", 32'(cyc), 32'(lat));
        end
        @(posedge clk);
        #2;
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        ifc.mem_ack = 1'b0;
        scramble_cmd();
        fill_rf();
        #1;
        outputs_zero("reset");
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;

        tb_rf[0] = 32'hA;
        tb_rf[1] = 32'hB;
        tb_rf[3] = 32'hD;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h100, 16'h000B, 0, 0);

        fill_rf();
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'h200, 16'h8001, 0, 0);

        rd_fix = 1'b1;
        rd_val = 32'h55;
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0004, 0, 0);
        rd_fix = 1'b0;

        fill_rf();
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h400, 16'h00C5, 2, 0);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h480, 16'h0F00, 2, 0);

        d0 = done_cnt;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h500, 16'h0000, 0, 1);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h600, 16'h1248, 1, 1);
        chk("ignored_start_done_count", 32'(done_cnt - d0), 32'd2);

        fill_rf();
        ack_mode = 0;
        expect_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h700, 16'h00F0);
        @(posedge clk);
        #2;
        is_load = 1'b1;
        up      = 1'b1;
        pre     = 1'b0;
        wback   = 1'b1;
        rn      = 4'd0;
        base    = 32'h700;
        reglist = 16'h00F0;
        start   = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        outputs_zero("midop");
        mq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #2;
        chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h700, 16'h00F0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] rl;
            fill_rf();
            salt = $urandom;
            rl = 16'($urandom);
            if (k % 7 == 0) rl = 16'd0;
            if (k % 5 == 1) rl = 16'h8000 | 16'($urandom_range(0, 3));
            run_op(1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 4'($urandom), $urandom, rl,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
